// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops DSIZE entries from a show-ahead FIFO and
// packs LANES of them into one output word, with flush for partial words.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int LANES = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [15:0]            word_cnt
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] FULL_C = CW'(LANES);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [CW-1:0]          slot;
  logic [DSIZE*LANES-1:0] acc, acc_nx;
  logic [LANES-1:0]       keep_nx;
  logic                   out_free;
  logic                   full;
  logic                   pop;
  logic                   load;
  logic                   load_last;

  assign out_free = !m_valid || m_ready;
  assign full     = (cnt == FULL_C);
  assign pop      = rrst_n && !rempty && (state == FILL)
                    && (!full || out_free);
  assign rinc     = pop;
  // A pop on the same edge as a full-word load lands in lane 0
  assign slot     = full ? '0 : cnt;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    load      = 1'b0;
    load_last = 1'b0;
    unique case (state)
      FILL: begin
        if (full && out_free) begin
          load   = 1'b1;
          acc_nx = '0;
          cnt_nx = '0;
        end
        if (pop) begin
          for (int i = 0; i < LANES; i++) begin
            if (CW'(i) == slot) begin
              acc_nx[DSIZE*i +: DSIZE] = rdata;
            end
          end
          cnt_nx = slot + CW'(1);
        end
        if (flush) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nx = FILL;
        end else if (out_free) begin
          load      = 1'b1;
          load_last = 1'b1;
          acc_nx    = '0;
          cnt_nx    = '0;
          state_nx  = FILL;
        end
      end
    endcase
  end

  always_comb begin
    keep_nx = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_nx[i] = (CW'(i) < cnt);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= FILL;
      cnt      <= '0;
      acc      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= acc;
        m_keep  <= keep_nx;
        m_last  <= load_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed vector table, corner sequences,
// and a randomized FIFO-order scoreboard.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rempty = 1'b1;
  logic        rinc;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] word_cnt;

  fifo_rd_packer #(.DSIZE(8), .LANES(4)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .flush    (flush),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .word_cnt (word_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          cyc;
  } wd_t;

  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          fl;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          xfers = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  popped_q[$];
  wd_t         got_q[$];
  bit          hold_p = 0;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;
  logic        hold_l;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit fl, input bit rdy, input bit stall,
                      output bit popped);
    wd_t w;
    @(negedge rclk);
    cyc++;
    flush   = fl;
    m_ready = rdy;
    rempty  = (fifo.size() == 0) || stall;
    rdata   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    if (hold_p) begin
      chk("hold_data", m_data, hold_d);
      chk("hold_keep", m_keep, hold_k);
      chk("hold_last", m_last, hold_l);
    end
    hold_p = m_valid && !m_ready;
    hold_d = m_data;
    hold_k = m_keep;
    hold_l = m_last;
    if (m_valid && m_ready) begin
      w.d = m_data;
      w.k = m_keep;
      w.l = m_last;
      w.cyc = cyc;
      got_q.push_back(w);
      xfers++;
    end
    popped = rinc;
    if (rinc) begin
      if (rempty) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: rinc 1 while rempty 1");
      end else begin
        popped_q.push_back(fifo.pop_front());
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    bit p;
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, p);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    rempty  = 1'b0;
    rdata   = 8'hEE;
    #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_last", m_last, 0);
    chk("rst_wcnt", word_cnt, 0);
    rempty = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
    fifo.delete();
    popped_q.delete();
    got_q.delete();
    xfers  = 0;
    hold_p = 0;
  endtask

  vec_t vecs[6];

  initial begin
    bit   p;
    int   pops;
    int   src;
    logic [7:0] out_s[$];

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1'b0};
    vecs[1] = '{3, 32'h00A3A2A1, 1'b1, 32'h00A3A2A1, 4'h7, 1'b1};
    vecs[2] = '{0, 32'h00000000, 1'b1, 32'h00000000, 4'h0, 1'b0};
    vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 1'b1};
    vecs[4] = '{2, 32'h0000BEEF, 1'b1, 32'h0000BEEF, 4'h3, 1'b1};
    vecs[5] = '{4, 32'hDDCCBBAA, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++)
        fifo.push_back(vecs[v].bytes[8*i +: 8]);
      run(vecs[v].n, 1'b1);
      if (vecs[v].fl) step(1'b1, 1'b1, 1'b0, p);
      run(8, 1'b1);
      chk($sformatf("v%0d_nwords", v), got_q.size(),
          (vecs[v].ek != 0) ? 1 : 0);
      if (got_q.size() > 0) begin
        chk($sformatf("v%0d_data", v), got_q[0].d, vecs[v].ed);
        chk($sformatf("v%0d_keep", v), got_q[0].k, vecs[v].ek);
        chk($sformatf("v%0d_last", v), got_q[0].l, vecs[v].el);
      end
      chk($sformatf("v%0d_wcnt", v), word_cnt,
          (vecs[v].ek != 0) ? 1 : 0);
    end

    // 12-entry stream at full rate
    do_reset();
    for (int i = 1; i <= 12; i++) fifo.push_back(8'(i));
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, p);
      pops += int'(p);
    end
    chk("stream_pops", pops, 12);
    run(8, 1'b1);
    chk("stream_nwords", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("stream_w0", got_q[0].d, 32'h04030201);
      chk("stream_w1", got_q[1].d, 32'h08070605);
      chk("stream_w2", got_q[2].d, 32'h0C0B0A09);
      chk("stream_slot1", got_q[1].cyc - got_q[0].cyc, 4);
      chk("stream_slot2", got_q[2].cyc - got_q[1].cyc, 4);
    end
    chk("stream_wcnt", word_cnt, 3);

    // backpressure with 8 queued entries
    do_reset();
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(8'h20 + i));
    pops = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 1'b0, p);
      pops += int'(p);
    end
    chk("bp_pops", pops, 8);
    chk("bp_rinc", rinc, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 32'h24232221);
    run(8, 1'b1);
    chk("bp_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_w0", got_q[0].d, 32'h24232221);
      chk("bp_w1", got_q[1].d, 32'h28272625);
    end

    // reset with held output and partial accumulator
    do_reset();
    for (int i = 1; i <= 6; i++) fifo.push_back(8'(8'hB0 + i));
    run(8, 1'b0);
    chk("mid_valid_pre", m_valid, 1);
    do_reset();
    for (int i = 1; i <= 4; i++) fifo.push_back(8'(8'hC0 + i));
    run(10, 1'b1);
    chk("post_rst_nwords", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("post_rst_data", got_q[0].d, 32'hC4C3C2C1);
      chk("post_rst_keep", got_q[0].k, 4'hF);
    end
    chk("post_rst_wcnt", word_cnt, 1);

    // randomized scoreboard over 4096 entries
    do_reset();
    src = 0;
    for (int t = 0; t < 40000; t++) begin
      if (src >= 4096 && fifo.size() == 0) break;
      for (int k = $urandom_range(0, 2); k > 0 && src < 4096; k--) begin
        fifo.push_back(8'(src));
        src++;
      end
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 4) == 0), p);
    end
    chk("rnd_drained", (src == 4096) && (fifo.size() == 0), 1);
    step(1'b1, 1'b1, 1'b0, p);
    run(12, 1'b1);
    foreach (got_q[w]) begin
      for (int i = 0; i < 4; i++) begin
        if (got_q[w].k[i]) out_s.push_back(got_q[w].d[8*i +: 8]);
        else if (got_q[w].d[8*i +: 8] !== 8'h00)
          chk("rnd_unused_lane", got_q[w].d[8*i +: 8], 0);
      end
      if (!got_q[w].l) chk("rnd_full_keep", got_q[w].k, 4'hF);
    end
    chk("rnd_count", out_s.size(), 4096);
    for (int i = 0; i < 4096 && i < out_s.size(); i++)
      if (out_s[i] !== 8'(i)) chk($sformatf("rnd_byte%0d", i), out_s[i], 8'(i));
    chk("rnd_order_ok", out_s.size() >= 1 && out_s[out_s.size()-1] == 8'hFF, 1);
    chk("rnd_wcnt", word_cnt, 16'(xfers));
    chk("rnd_valid_idle", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001: Parameter DSIZE, default 8, width of one FIFO entry (byte lane).
REQ-002: Parameter LANES, default 4, lanes per output word; power of two, 2..8.
REQ-003: rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-004: rrst_n  input  1  reset, asynchronous, active-low.
REQ-005: rdata  input  DSIZE  FIFO head entry, valid whenever rempty=0 (show-ahead).
REQ-006: rempty  input  1  FIFO empty flag, synchronous to rclk.
REQ-007: rinc  output  1  FIFO pop; an entry is consumed at each rising edge where rinc=1 and rempty=0.
REQ-008: flush  input  1  single-cycle request to emit the partial word.
REQ-009: m_data  output  DSIZE*LANES  packed word; lane i = bits [DSIZE*i +: DSIZE].
REQ-010: m_keep  output  LANES  per-lane valid mask, contiguous from lane 0.
REQ-011: m_last  output  1  word closed by a flush.
REQ-012: m_valid  output  1  output word valid.
REQ-013: m_ready  input  1  downstream accepts; transfer when m_valid=1 and m_ready=1.
REQ-014: word_cnt  output  16  count of transferred words, wraps 0xFFFF->0.

Function
REQ-015: Accumulator holds LANES lanes plus fill count cnt (0..LANES); popped entries fill lanes in FIFO order, first entry in lane 0.
REQ-016: Output register holds one word; "out_free" = (m_valid=0) or (m_ready=1).
REQ-017: FSM states FILL and FLUSH; reset state FILL.
REQ-018: rinc = (rempty=0) and state=FILL and ((cnt<LANES) or out_free); rinc combinational; rinc=0 during reset.
REQ-019: FILL, cnt=LANES and out_free: accumulator moves to output register (m_keep=all ones, m_last=0), m_valid=1; a simultaneous pop writes lane 0 and cnt becomes 1, else cnt becomes 0.
REQ-020: FILL, cnt<LANES: a pop writes lane cnt, cnt increments; no output load.
REQ-021: Sustained throughput one entry per rclk cycle while rempty=0 and m_ready=1; first word m_valid rises at the edge after the LANES-th pop edge.
REQ-022: flush=1 in FILL: go to FLUSH at that edge; any pop on that same edge is still accepted and counted in the flushed word.
REQ-023: flush=1 while already in FLUSH is ignored.
REQ-024: FLUSH, cnt=0: return to FILL, no output word.
REQ-025: FLUSH, cnt>0 and out_free: load output with lanes 0..cnt-1, m_keep lower cnt bits set, unused lanes zero, m_last=1; cnt becomes 0; return to FILL.
REQ-026: FLUSH, output not free: hold, no pops, until out_free.
REQ-027: m_data, m_keep, m_last stable while m_valid=1 and m_ready=0.
REQ-028: m_valid clears at a transfer edge unless a new word loads on that edge.
REQ-029: word_cnt increments by 1 on each transfer edge.
REQ-030: Unused accumulator lanes are zero in any emitted word.

Reset
REQ-031: rrst_n=0 asynchronously forces: state FILL, cnt=0, accumulator zero, m_valid=0, m_data=0, m_keep=0, m_last=0, word_cnt=0, rinc=0.
REQ-032: Reset mid-word discards partial data and any held output; no word is emitted after release until LANES new pops.
REQ-033: First pop allowed at first rising edge after rrst_n deasserts.

Verification
REQ-034: FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 -> one word m_data=0x44332211, m_keep=4'hF, m_last=0, word_cnt=1.
REQ-035: 12 entries 0x01..0x0C streamed, m_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09 on consecutive word slots, rinc high 12 consecutive cycles.
REQ-036: 0xA1,0xA2,0xA3 then flush -> m_data=0x00A3A2A1, m_keep=4'h7, m_last=1; flush with cnt=0 -> no word.
REQ-037: m_ready=0 with 8 entries queued -> exactly 8 pops then rinc=0, m_data stable at 0x.. first word; m_ready=1 -> both words delivered in order.
REQ-038: rrst_n pulsed low after 2 pops -> m_valid=0, word_cnt=0; next 4 pops produce a word with no stale lanes.
REQ-039: Scoreboard: random rempty/m_ready/flush over 4096 entries -> concatenated kept lanes equal FIFO order exactly, word_cnt matches transfers.
